// File: rtl/router_pkt_drain.sv
// Router output-port drain: pops the port FIFO, frames bytes as header/payload/parity packets,
// forwards them through a 2-entry skid buffer and checks parity. Optional abort: DRAIN_TIMEOUT_EN.
module router_pkt_drain #(
    parameter int unsigned CNT_W = 16
`ifdef DRAIN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 30
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dout,
    output logic             read_en,
    output logic [7:0]       pkt_data,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             pkt_sop,
    output logic             pkt_eop,
    output logic             pkt_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_PAY = 2'd1,
        ST_PAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } skid_ent_t;

    state_t     state_q, state_d;
    logic [5:0] rem_q, rem_d;
    logic [7:0] par_q, par_d;
    logic       inflight_q;
    logic [1:0] occ_q, occ_d;
    logic       valid_q;
    skid_ent_t  head_q, tail_q, in_ent;
    logic       push_c, pop_c, abort_c;
    logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

`ifdef DRAIN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;
    logic            abort_due_c;

    assign abort_due_c = (state_q != ST_HDR) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`endif

    // Pop only while the skid buffer can absorb every byte already requested.
    assign read_en = !rst && !fifo_empty && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
    assign pop_c   = valid_q && pkt_ready;

    assign pkt_valid = valid_q;
    assign pkt_data  = head_q.data;
    assign pkt_sop   = head_q.sop;
    assign pkt_eop   = head_q.eop;
    assign pkt_err   = head_q.err;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;

    // Framing FSM: next state and tags for the byte entering the skid buffer.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        par_d   = par_q;
        push_c  = 1'b0;
        abort_c = 1'b0;
        in_ent  = '0;
        if (inflight_q) begin
            push_c      = 1'b1;
            in_ent.data = fifo_dout;
            unique case (state_q)
                ST_HDR: begin
                    in_ent.sop = 1'b1;
                    rem_d      = fifo_dout[7:2];
                    par_d      = fifo_dout;
                    state_d    = (fifo_dout[7:2] != 6'd0) ? ST_PAY : ST_PAR;
                end
                ST_PAY: begin
                    par_d = par_q ^ fifo_dout;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d = ST_PAR;
                    end
                end
                ST_PAR: begin
                    in_ent.eop = 1'b1;
                    in_ent.err = (par_q != fifo_dout);
                    state_d    = ST_HDR;
                end
                default: state_d = ST_HDR;
            endcase
        end
`ifdef DRAIN_TIMEOUT_EN
        // Expiry implies nothing is in flight; the abort byte waits for a free slot.
        else if (abort_due_c && (occ_q != 2'd2)) begin
            push_c     = 1'b1;
            abort_c    = 1'b1;
            in_ent.eop = 1'b1;
            in_ent.err = 1'b1;
            state_d    = ST_HDR;
        end
`endif
    end

    always_comb begin
        occ_d = occ_q;
        unique case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HDR;
            rem_q      <= '0;
            par_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            par_q      <= par_d;
            inflight_q <= read_en;
        end
    end

    // Skid buffer: head drives the consumer port, tail holds the second entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
            unique case ({push_c, pop_c})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= in_ent;
                    end else begin
                        tail_q <= in_ent;
                    end
                end
                2'b01: begin
                    if (occ_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= in_ent;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (pop_c && head_q.eop) begin
            if (pkt_cnt_q != '1) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
            if (head_q.err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef DRAIN_TIMEOUT_EN
    // Counts starved cycles mid-packet; idle in HDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort_c;
            if ((state_q == ST_HDR) || abort_c || read_en) begin
                to_cnt_q <= '0;
            end else if (fifo_empty && !inflight_q && (to_cnt_q != TO_W'(TIMEOUT_CYCLES))) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_drain.sv
// Scoreboard bench for router_pkt_drain: a FIFO model feeds directed packets, a negedge
// monitor compares every accepted byte against the expected queue.
module tb_router_pkt_drain;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_dout = 8'h00;
    logic             read_en;
    logic [7:0]       pkt_data;
    logic             pkt_valid;
    logic             pkt_ready = 1'b1;
    logic             pkt_sop;
    logic             pkt_eop;
    logic             pkt_err;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             timeout;

    logic [7:0] fq[$];
    logic [7:0] pb[$];
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_pkt = 0;
    int         exp_err = 0;

    router_pkt_drain #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .read_en    (read_en),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_sop    (pkt_sop),
        .pkt_eop    (pkt_eop),
        .pkt_err    (pkt_err),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Source FIFO with one-cycle registered read data.
    always @(posedge clk) begin
        if (read_en && !fifo_empty) begin
            fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic sop, input logic eop, input logic err);
        exp_t e;
        e.data = b;
        e.sop  = sop;
        e.eop  = eop;
        e.err  = err;
        fq.push_back(b);
        exp_q.push_back(e);
    endtask

    // Sends the bytes in pb as one complete packet with a hand-given error flag.
    task automatic send_pkt(input logic err_exp);
        for (int i = 0; i < pb.size(); i++) begin
            push_byte(pb[i], i == 0, i == pb.size() - 1, err_exp && (i == pb.size() - 1));
        end
        exp_pkt++;
        if (err_exp) exp_err++;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && fq.size() == 0 && !pkt_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_drained"}, 32'(done), 32'd1);
        tick();
        chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, 32'(pkt_valid), 32'd0);
        chk({name, "_sop"}, 32'(pkt_sop), 32'd0);
        chk({name, "_eop"}, 32'(pkt_eop), 32'd0);
        chk({name, "_err"}, 32'(pkt_err), 32'd0);
        chk({name, "_data"}, 32'(pkt_data), 32'd0);
        chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({name, "_timeout"}, 32'(timeout), 32'd0);
        chk({name, "_read_en"}, 32'(read_en), 32'd0);
    endtask

    // Monitor: every byte the consumer accepts must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", pkt_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_data", 32'(pkt_data), 32'(e.data));
                    chk("mon_sop", 32'(pkt_sop), 32'(e.sop));
                    chk("mon_eop", 32'(pkt_eop), 32'(e.eop));
                    chk("mon_err", 32'(pkt_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Good packet, len 3.
        pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(1'b0);
        drain("t1");

        // Same packet with a bad parity byte.
        pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF};
        send_pkt(1'b1);
        drain("t2");

        // Zero-length packet.
        pb = '{8'h02, 8'h02};
        send_pkt(1'b0);
        drain("t3");

        // Back-to-back packets with a consumer stall inside the first one.
        pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(1'b0);
        pb = '{8'h09, 8'hAA, 8'h55, 8'hF6};
        send_pkt(1'b0);
        repeat (4) tick();
        pkt_ready = 1'b0;
        repeat (10) tick();
        chk("t4_stall_read_en", 32'(read_en), 32'd0);
        chk("t4_stall_valid", 32'(pkt_valid), 32'd1);
        chk("t4_stall_data", 32'(pkt_data), 32'h11);
        pkt_ready = 1'b1;
        drain("t4");

        // Reset one cycle after popping the last buffered payload byte.
        push_byte(8'h0D, 1'b1, 1'b0, 1'b0);
        push_byte(8'h11, 1'b0, 1'b0, 1'b0);
        push_byte(8'h22, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (read_en && !fifo_empty && fq.size() == 1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_pop_seen", 32'(found), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t5_reset");
        exp_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        rst = 1'b0;
        tick();
        pb = '{8'h02, 8'h02};
        send_pkt(1'b0);
        drain("t5");

`ifdef DRAIN_TIMEOUT_EN
        // Starved packet aborts with a synthetic error byte.
        found = 1'b0;
        push_byte(8'h10, 1'b1, 1'b0, 1'b0);
        push_byte(8'h01, 1'b0, 1'b0, 1'b0);
        push_byte(8'h02, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{data: 8'h00, sop: 1'b0, eop: 1'b1, err: 1'b1});
        exp_pkt++;
        exp_err++;
        for (int i = 0; i < 100; i++) begin
            if (timeout) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_timeout_seen", 32'(found), 32'd1);
        tick();
        chk("t6_timeout_pulse", 32'(timeout), 32'd0);
        drain("t6");
`else
        // Starved packet simply waits, then completes.
        push_byte(8'h10, 1'b1, 1'b0, 1'b0);
        push_byte(8'h01, 1'b0, 1'b0, 1'b0);
        push_byte(8'h02, 1'b0, 1'b0, 1'b0);
        repeat (60) tick();
        chk("t6_no_timeout", 32'(timeout), 32'd0);
        chk("t6_waiting_valid", 32'(pkt_valid), 32'd0);
        chk("t6_waiting_cnt", 32'(pkt_cnt), 32'(exp_pkt));
        push_byte(8'h03, 1'b0, 1'b0, 1'b0);
        push_byte(8'h04, 1'b0, 1'b0, 1'b0);
        push_byte(8'h14, 1'b0, 1'b1, 1'b0);
        exp_pkt++;
        drain("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
